// File: rtl/mips_datapath_pkg.sv
// mips_datapath_pkg: shared constants for the single-cycle MIPS-subset datapath.
//   - opcode and R-type funct codes of the supported instructions
//   - ALU operation encoding (alu_op_e) and the decoded control word (ctrl_t)
//   - funct helpers that map an R-type funct onto an ALU operation
package mips_datapath_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_NOR = 6'h27;
  localparam logic [5:0] FN_SLT = 6'h2A;

  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_AND = 3'd2,
    ALU_OR  = 3'd3,
    ALU_NOR = 3'd4,
    ALU_SLT = 3'd5
  } alu_op_e;

  // Decoded control word; the all-zero value is a harmless NOP that adds.
  typedef struct packed {
    logic    reg_write;   // write the register file
    logic    dst_rd;      // destination is rd (R-type) rather than rt
    logic    imm_src;     // ALU operand B is the extended immediate
    logic    zero_ext;    // zero-extend the immediate (andi/ori)
    logic    mem_to_reg;  // write-back data comes from data memory
    logic    mem_write;   // store rt into data memory
    logic    branch;      // beq
    logic    jump;        // j
    alu_op_e alu_op;
  } ctrl_t;

  function automatic logic funct_valid(input logic [5:0] funct);
    return (funct == FN_ADD) || (funct == FN_SUB) || (funct == FN_AND) ||
           (funct == FN_OR)  || (funct == FN_NOR) || (funct == FN_SLT);
  endfunction

  function automatic alu_op_e funct_to_alu(input logic [5:0] funct);
    case (funct)
      FN_SUB:  return ALU_SUB;
      FN_AND:  return ALU_AND;
      FN_OR:   return ALU_OR;
      FN_NOR:  return ALU_NOR;
      FN_SLT:  return ALU_SLT;
      default: return ALU_ADD;
    endcase
  endfunction

endpackage

// File: rtl/mips_datapath_alu.sv
// alu: 32-bit combinational ALU of the datapath.
//   a, b : operands
//   op   : operation (alu_op_e)
//   y    : result; add/sub wrap modulo 2^32, slt is a signed compare giving 1/0
module alu
  import mips_datapath_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  alu_op_e     op,
  output logic [31:0] y
);

  always_comb begin
    // NOTE: a default before the case keeps every path assigned, so no latch is inferred.
    y = a + b;
    case (op)
      ALU_SUB: y = a - b;
      ALU_AND: y = a & b;
      ALU_OR:  y = a | b;
      ALU_NOR: y = ~(a | b);
      ALU_SLT: y = {31'd0, $signed(a) < $signed(b)};
      default: y = a + b;
    endcase
  end

endmodule

// File: rtl/mips_datapath_mem.sv
// Storage blocks of the datapath; none is cleared by reset, the bench preloads them.
//   mips_imem    : byte-wide instruction memory MR, big-endian 32-bit fetch at pc,
//                  addresses wrap modulo IMEM_BYTES; load_* is a loader write port
//   mips_regfile : 32x32 register file mem, two combinational reads, one clocked write;
//                  register 0 reads as zero and ignores writes
//   mips_dmem    : word-wide data memory mem2, index = addr[31:2] modulo DMEM_WORDS,
//                  combinational read, clocked write
module mips_imem #(
  parameter int IMEM_BYTES = 256
) (
  input  logic        clk,
  input  logic        load_en,
  input  logic [31:0] load_addr,
  input  logic [7:0]  load_data,
  input  logic [31:0] pc,
  output logic [31:0] instr
);

  localparam int          AW    = (IMEM_BYTES > 1) ? $clog2(IMEM_BYTES) : 1;
  localparam logic [31:0] DEPTH = 32'(IMEM_BYTES);

  logic [7:0] MR [IMEM_BYTES];

  always_ff @(posedge clk) begin
    if (load_en) MR[AW'(load_addr % DEPTH)] <= load_data;
  end

  assign instr = {MR[AW'(pc % DEPTH)],
                  MR[AW'((pc + 32'd1) % DEPTH)],
                  MR[AW'((pc + 32'd2) % DEPTH)],
                  MR[AW'((pc + 32'd3) % DEPTH)]};

endmodule

module mips_regfile (
  input  logic        clk,
  input  logic        we,
  input  logic [4:0]  ra1,
  input  logic [4:0]  ra2,
  input  logic [4:0]  wa,
  input  logic [31:0] wd,
  output logic [31:0] rd1,
  output logic [31:0] rd2
);

  logic [31:0] mem [32];

  // NOTE: storage arrays carry no reset; only control state (the PC) is reset.
  always_ff @(posedge clk) begin
    if (we && (wa != 5'd0)) mem[wa] <= wd;
  end

  assign rd1 = (ra1 == 5'd0) ? 32'd0 : mem[ra1];
  assign rd2 = (ra2 == 5'd0) ? 32'd0 : mem[ra2];

endmodule

module mips_dmem #(
  parameter int DMEM_WORDS = 64
) (
  input  logic        clk,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] wd,
  output logic [31:0] rd
);

  localparam int          AW    = (DMEM_WORDS > 1) ? $clog2(DMEM_WORDS) : 1;
  localparam logic [31:0] DEPTH = 32'(DMEM_WORDS);

  logic [31:0]   mem2 [DMEM_WORDS];
  logic [AW-1:0] idx;

  assign idx = AW'((addr >> 2) % DEPTH);
  assign rd  = mem2[idx];

  always_ff @(posedge clk) begin
    if (we) mem2[idx] <= wd;
  end

endmodule

// File: rtl/mips_datapath.sv
// mips_datapath: single-cycle 32-bit MIPS-subset datapath (one instruction per clk rise).
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset; clears only the PC and blocks all writes
//   pru   : ALU result of the current instruction (debug tap)
//   prum  : data-memory word at the current ALU-result index (debug tap)
// Instances p3 (imem, MR), p7 (regfile, mem) and p16 (dmem, mem2) are preloaded by the bench.
module mips_datapath
  import mips_datapath_pkg::*;
#(
  parameter int IMEM_BYTES = 256,
  parameter int DMEM_WORDS = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] pru,
  output logic [31:0] prum
);

  logic [31:0] pc, pc_next, pc_plus4, instr;
  logic [31:0] rs_val, rt_val, imm_ext, alu_b, alu_y, dmem_rd, wb_data;
  logic [5:0]  opcode, funct;
  logic [4:0]  rs, rt, rd, waddr;
  logic [15:0] imm;
  ctrl_t       ctrl;

  assign opcode = instr[31:26];
  assign rs     = instr[25:21];
  assign rt     = instr[20:16];
  assign rd     = instr[15:11];
  assign imm    = instr[15:0];
  assign funct  = instr[5:0];

  mips_imem #(.IMEM_BYTES(IMEM_BYTES)) p3 (
    .clk       (clk),
    .load_en   (1'b0),
    .load_addr (32'd0),
    .load_data (8'd0),
    .pc        (pc),
    .instr     (instr)
  );

  always_comb begin
    ctrl = '0;
    case (opcode)
      OP_RTYPE: begin
        ctrl.reg_write = funct_valid(funct);  // unknown funct is a NOP
        ctrl.dst_rd    = 1'b1;
        ctrl.alu_op    = funct_to_alu(funct);
      end
      OP_ADDI: begin
        ctrl.reg_write = 1'b1;
        ctrl.imm_src   = 1'b1;
      end
      OP_SLTI: begin
        ctrl.reg_write = 1'b1;
        ctrl.imm_src   = 1'b1;
        ctrl.alu_op    = ALU_SLT;
      end
      OP_ANDI: begin
        ctrl.reg_write = 1'b1;
        ctrl.imm_src   = 1'b1;
        ctrl.zero_ext  = 1'b1;
        ctrl.alu_op    = ALU_AND;
      end
      OP_ORI: begin
        ctrl.reg_write = 1'b1;
        ctrl.imm_src   = 1'b1;
        ctrl.zero_ext  = 1'b1;
        ctrl.alu_op    = ALU_OR;
      end
      OP_LW: begin
        ctrl.reg_write  = 1'b1;
        ctrl.imm_src    = 1'b1;
        ctrl.mem_to_reg = 1'b1;
      end
      OP_SW: begin
        ctrl.imm_src   = 1'b1;
        ctrl.mem_write = 1'b1;
      end
      OP_BEQ: begin
        ctrl.branch = 1'b1;
        ctrl.alu_op = ALU_SUB;
      end
      OP_J:    ctrl.jump = 1'b1;
      default: ctrl = '0;
    endcase
  end

  assign imm_ext = ctrl.zero_ext ? {16'd0, imm} : {{16{imm[15]}}, imm};
  assign alu_b   = ctrl.imm_src ? imm_ext : rt_val;
  assign waddr   = ctrl.dst_rd ? rd : rt;
  assign wb_data = ctrl.mem_to_reg ? dmem_rd : alu_y;

  // Writes are gated by rst_n so nothing architectural changes while reset is held.
  mips_regfile p7 (
    .clk (clk),
    .we  (ctrl.reg_write & rst_n),
    .ra1 (rs),
    .ra2 (rt),
    .wa  (waddr),
    .wd  (wb_data),
    .rd1 (rs_val),
    .rd2 (rt_val)
  );

  alu u_alu (
    .a  (rs_val),
    .b  (alu_b),
    .op (ctrl.alu_op),
    .y  (alu_y)
  );

  mips_dmem #(.DMEM_WORDS(DMEM_WORDS)) p16 (
    .clk  (clk),
    .we   (ctrl.mem_write & rst_n),
    .addr (alu_y),
    .wd   (rt_val),
    .rd   (dmem_rd)
  );

  assign pru  = alu_y;
  assign prum = dmem_rd;

  assign pc_plus4 = pc + 32'd4;

  always_comb begin
    pc_next = pc_plus4;
    if (ctrl.jump)
      pc_next = {pc_plus4[31:28], instr[25:0], 2'b00};
    else if (ctrl.branch && (rs_val == rt_val))
      pc_next = pc_plus4 + {imm_ext[29:0], 2'b00};
  end

  // NOTE: sequential state uses non-blocking assignment so all flops update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pc <= 32'd0;
    else        pc <= pc_next;
  end

endmodule

// File: tb/tb_mips_datapath.sv
// tb_mips_datapath: scoreboard bench for mips_datapath. The stimulus process places
// each instruction at the model PC, runs an architectural reference model, and queues
// the expected PC/pru/prum/register/memory values; a negedge monitor compares them.
module tb_mips_datapath;
  import mips_datapath_pkg::*;

  localparam int IMEM = 256;
  localparam int DMEM = 64;
  localparam logic [31:0] REG0_JUNK = 32'hA5A5_A5A5;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] pru, prum;

  mips_datapath #(.IMEM_BYTES(IMEM), .DMEM_WORDS(DMEM)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .pru   (pru),
    .prum  (prum)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef enum {K_PC, K_PRU, K_PRUM, K_REG, K_DMEM} kind_e;
  typedef struct {
    kind_e       kind;
    int          idx;
    logic [31:0] exp;
    int          due;
    string       name;
  } exp_t;

  exp_t sbq[$];
  exp_t cur;
  int   n_vec = 0;
  int   n_err = 0;

  logic [31:0] m_reg  [32];
  logic [31:0] m_dmem [DMEM];
  logic [31:0] m_pc;

  task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h, expected %08h", nm, act, exp);
    end
  endtask

  task automatic push(kind_e k, int idx, logic [31:0] v, int due, string nm);
    exp_t e;
    e.kind = k; e.idx = idx; e.exp = v; e.due = due; e.name = nm;
    sbq.push_back(e);
  endtask

  function automatic logic [31:0] actual(kind_e k, int idx);
    case (k)
      K_PC:    return dut.pc;
      K_PRU:   return pru;
      K_PRUM:  return prum;
      K_REG:   return dut.p7.mem[idx];
      default: return dut.p16.mem2[idx];
    endcase
  endfunction

  // Monitor: everything due by this cycle is compared half a period after the edge.
  always @(negedge clk) begin
    while (sbq.size() > 0 && sbq[0].due <= cyc) begin
      cur = sbq.pop_front();
      check(cur.name, actual(cur.kind, cur.idx), cur.exp);
    end
  end

  // ---------------- reference model ----------------
  function automatic logic [31:0] rr(logic [4:0] i);
    return (i == 5'd0) ? 32'd0 : m_reg[i];
  endfunction

  function automatic logic [31:0] reg_store(logic [4:0] i);
    return (i == 5'd0) ? REG0_JUNK : m_reg[i];
  endfunction

  function automatic int didx(logic [31:0] addr);
    return int'((addr / 4) % DMEM);
  endfunction

  task automatic place(logic [31:0] ins);
    for (int k = 0; k < 4; k++)
      dut.p3.MR[(m_pc + 32'(k)) % IMEM] = ins[31-8*k -: 8];
  endtask

  // Execute one instruction: model it, queue expectations, then let one clk rise pass.
  task automatic issue(logic [31:0] ins, string tag);
    logic [5:0]  op   = ins[31:26];
    logic [4:0]  rs   = ins[25:21];
    logic [4:0]  rt   = ins[20:16];
    logic [4:0]  rd   = ins[15:11];
    logic [5:0]  fn   = ins[5:0];
    logic [31:0] a    = rr(rs);
    logic [31:0] b    = rr(rt);
    logic [31:0] simm = {{16{ins[15]}}, ins[15:0]};
    logic [31:0] zimm = {16'd0, ins[15:0]};
    logic [31:0] res  = 32'd0;
    logic [31:0] val;
    logic [31:0] npc  = m_pc + 32'd4;
    logic        has_alu = 1'b1;
    logic        wr   = 1'b0;
    logic [4:0]  dst  = rt;
    logic        st   = 1'b0;

    place(ins);
    case (op)
      6'h00: begin
        dst = rd;
        wr  = 1'b1;
        case (fn)
          6'h20:   res = a + b;
          6'h22:   res = a - b;
          6'h24:   res = a & b;
          6'h25:   res = a | b;
          6'h27:   res = ~(a | b);
          6'h2A:   res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
          default: begin wr = 1'b0; has_alu = 1'b0; end
        endcase
      end
      6'h08: begin res = a + simm; wr = 1'b1; end
      6'h0A: begin res = ($signed(a) < $signed(simm)) ? 32'd1 : 32'd0; wr = 1'b1; end
      6'h0C: begin res = a & zimm; wr = 1'b1; end
      6'h0D: begin res = a | zimm; wr = 1'b1; end
      6'h23: begin res = a + simm; wr = 1'b1; end
      6'h2B: begin res = a + simm; st = 1'b1; end
      6'h04: begin has_alu = 1'b0; if (a == b) npc = m_pc + 32'd4 + (simm << 2); end
      6'h02: begin has_alu = 1'b0; npc = {npc[31:28], ins[25:0], 2'b00}; end
      default: has_alu = 1'b0;
    endcase
    val = (op == 6'h23) ? m_dmem[didx(res)] : res;

    push(K_PC, 0, m_pc, cyc, {tag, " pc"});
    if (has_alu) begin
      push(K_PRU, 0, res, cyc, {tag, " pru"});
      push(K_PRUM, 0, m_dmem[didx(res)], cyc, {tag, " prum"});
    end
    if (wr && dst != 5'd0) m_reg[dst] = val;
    if (st) begin
      m_dmem[didx(res)] = b;
      push(K_DMEM, didx(res), b, cyc + 1, $sformatf("%s dmem%0d", tag, didx(res)));
    end else begin
      // The would-be destination must hold its modelled value (unchanged for NOPs and $0).
      push(K_REG, int'(dst), reg_store(dst), cyc + 1, $sformatf("%s reg%0d", tag, dst));
    end
    m_pc = npc;
    @(posedge clk);
    #1;
  endtask

  // ---------------- encoders and random generator ----------------
  function automatic logic [31:0] r_ins(logic [5:0] fn, logic [4:0] rd, logic [4:0] rs, logic [4:0] rt);
    return {6'h00, rs, rt, rd, 5'd0, fn};
  endfunction

  function automatic logic [31:0] i_ins(logic [5:0] op, logic [4:0] rt, logic [4:0] rs, logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] j_ins(logic [25:0] t);
    return {6'h02, t};
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [5:0]  fns [6] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h27, 6'h2A};
    logic [5:0]  bad [3] = '{6'h01, 6'h05, 6'h3F};
    int          sel = int'($urandom_range(0, 15));
    logic [4:0]  rs  = 5'($urandom_range(0, 7));
    logic [4:0]  rt  = 5'($urandom_range(0, 7));
    logic [4:0]  rd  = 5'($urandom_range(0, 15));
    logic [15:0] imm = 16'($urandom);
    case (sel)
      0, 1, 2, 3, 4, 5: return r_ins(fns[sel], rd, rs, rt);
      6:  return r_ins(6'($urandom_range(0, 15)), rd, rs, rt);
      7:  return i_ins(6'h08, rt, rs, imm);
      8:  return i_ins(6'h0A, rt, rs, imm);
      9:  return i_ins(6'h0C, rt, rs, imm);
      10: return i_ins(6'h0D, rt, rs, imm);
      11: return i_ins(6'h23, rt, rs, imm);
      12: return i_ins(6'h2B, rt, rs, imm);
      13: begin
        if ($urandom_range(0, 1) == 1) rt = rs;
        return i_ins(6'h04, rt, rs, 16'(int'($urandom_range(0, 6)) - 3));
      end
      14: return j_ins(26'($urandom_range(0, 32'h3FFFF)));
      default: return i_ins(bad[$urandom_range(0, 2)], rt, rs, imm);
    endcase
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    rst_n = 1'b0;
    for (int i = 0; i < IMEM; i++) dut.p3.MR[i] = 8'h00;
    for (int i = 1; i < 32; i++) m_reg[i] = $urandom;
    m_reg[0] = 32'd0;
    m_reg[1] = 32'd5;
    m_reg[2] = 32'd7;
    for (int i = 1; i < 32; i++) dut.p7.mem[i] = m_reg[i];
    dut.p7.mem[0] = REG0_JUNK;
    for (int i = 0; i < DMEM; i++) m_dmem[i] = $urandom;
    m_dmem[2] = 32'hDEAD_BEEF;
    for (int i = 0; i < DMEM; i++) dut.p16.mem2[i] = m_dmem[i];
    m_pc = 32'd0;

    repeat (3) @(posedge clk);
    #1;
    push(K_PC, 0, 32'd0, cyc, "reset pc");
    rst_n = 1'b1;

    issue(r_ins(6'h20, 5'd3, 5'd1, 5'd2), "add");
    issue(r_ins(6'h22, 5'd4, 5'd1, 5'd2), "sub");
    issue(r_ins(6'h2A, 5'd5, 5'd1, 5'd2), "slt");
    issue(i_ins(6'h23, 5'd6, 5'd0, 16'd8), "lw");
    issue(i_ins(6'h2B, 5'd1, 5'd0, 16'd12), "sw");
    issue(i_ins(6'h08, 5'd0, 5'd0, 16'd9), "addi r0");
    issue(i_ins(6'h0D, 5'd7, 5'd0, 16'hFFFF), "ori");
    issue(i_ins(6'h08, 5'd8, 5'd0, 16'hFFFF), "addi -1");
    issue(j_ins(26'd0), "j 0");
    issue(i_ins(6'h04, 5'd1, 5'd1, 16'd2), "beq taken");
    issue(j_ins(26'd0), "j 0");
    issue(i_ins(6'h04, 5'd2, 5'd1, 16'd2), "beq not taken");
    issue(j_ins(26'h10), "j 0x10");
    issue(r_ins(6'h00, 5'd9, 5'd1, 5'd2), "bad funct");

    for (int n = 0; n < 300; n++) issue(rand_instr(), $sformatf("rnd%0d", n));

    // Asynchronous reset in the middle of a cycle while PC = 0x20.
    issue(j_ins(26'd8), "j 8");
    #1;
    rst_n = 1'b0;
    m_pc  = 32'd0;
    push(K_PC, 0, 32'd0, cyc, "async reset pc");
    place(i_ins(6'h08, 5'd9, 5'd0, 16'h1234));
    push(K_REG, 9, m_reg[9], cyc + 1, "reset no reg write");
    push(K_PC, 0, 32'd0, cyc + 1, "reset pc held");
    @(posedge clk);
    #1;
    place(i_ins(6'h2B, 5'd2, 5'd0, 16'd16));
    push(K_DMEM, 4, m_dmem[4], cyc + 1, "reset no mem write");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    issue(r_ins(6'h20, 5'd10, 5'd1, 5'd2), "post-reset add");
    for (int n = 0; n < 4; n++) issue(rand_instr(), $sformatf("post%0d", n));

    for (int i = 0; i < 20 && sbq.size() > 0; i++) @(negedge clk);
    #1;
    check("scoreboard drained", 32'(sbq.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1);
  end

endmodule

// File: doc/mips_datapath.md
MIPS_DATAPATH -- requirements
Module: mips_datapath

Interface
REQ-001 Parameter IMEM_BYTES, default 256, instruction-memory depth in bytes.
REQ-002 Parameter DMEM_WORDS, default 64, data-memory depth in 32-bit words.
REQ-003 Port clk  input  1  sole clock, rising-edge active.
REQ-004 Port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 Port pru  output  32  current ALU result, combinational debug tap.
REQ-006 Port prum  output  32  current data-memory read word, combinational debug tap.

Function
REQ-007 The block SHALL be a single-cycle 32-bit MIPS-subset datapath: one instruction completes per clk rising edge.
REQ-008 PC: 32-bit register; next PC = PC+4, the branch target, or the jump target; updated on each clk rise.
REQ-009 Instruction fetch: combinational, byte-addressed, big-endian; instr = {MR[PC], MR[PC+1], MR[PC+2], MR[PC+3]}.
REQ-010 Register file: 32x32, two combinational read ports (rs, rt), one write port written on the clk rise; a read of register 0 always returns 0, and writes to register 0 are ignored.
REQ-011 R-type (opcode 0) funct codes: 0x20 add, 0x22 sub, 0x24 and, 0x25 or, 0x27 nor, 0x2A slt (signed, result 1/0); destination rd.
REQ-012 Any other R-type funct SHALL make no register write (NOP).
REQ-013 I-type: 0x08 addi, 0x0A slti, 0x0C andi, 0x0D ori; destination rt.
REQ-014 Immediate extension: sign-extended for addi/slti/lw/sw/beq, zero-extended for andi/ori.
REQ-015 Arithmetic: add/sub wrap modulo 2^32; no overflow trap.
REQ-016 lw (0x23): rt <= DMEM[(rs+simm)>>2]; sw (0x2B): DMEM[(rs+simm)>>2] <= rt on the clk rise.
REQ-017 Data memory: word array of DMEM_WORDS entries; index = byte address bits above [1:0], modulo DMEM_WORDS; the read is combinational.
REQ-018 beq (0x04): if rs==rt, next PC = PC+4+(simm<<2); otherwise PC+4.
REQ-019 j (0x02): next PC = {PC+4[31:28], target26, 2'b00}.
REQ-020 Unsupported opcode: no register or memory write; next PC = PC+4.
REQ-021 Fetch beyond IMEM_BYTES-1 SHALL wrap modulo IMEM_BYTES.
REQ-022 pru = ALU output of the current instruction; prum = DMEM word at the current ALU-result index, regardless of opcode.

Reset
REQ-023 rst_n low SHALL force PC to 0 immediately, without waiting for clk, and hold it there while low.
REQ-024 Register file and memories SHALL NOT be cleared by reset; their contents are preloaded by the bench.
REQ-025 While rst_n is low, no register or memory write SHALL occur.
REQ-026 Release of rst_n SHALL let the instruction at address 0 execute on the next clk rise.

Structure
REQ-027 A shared package SHALL hold the opcode, funct and ALU-operation constants, plus the ALU-control encoding.
REQ-028 Instance names and arrays SHALL be fixed for bench preloading:
- p3: instruction memory, array MR, 8-bit entries.
- p7: register file, array mem, 32x32.
- p16: data memory, array mem2, 32-bit entries.
REQ-029 The ALU is the natural separate sub-module, named alu.
REQ-030 Control decode and PC logic SHALL be in the top.

Verification
REQ-031 Reg 1=5, reg 2=7; add $3,$1,$2 at PC 0 -> after one clk, reg 3=12 and pru showed 12 during the cycle.
REQ-032 sub $4,$1,$2 with the same preload -> reg 4=0xFFFFFFFE; slt $5,$1,$2 -> reg 5=1.
REQ-033 DMEM word 2=0xDEADBEEF; lw $6,8($0) -> prum=0xDEADBEEF during the cycle, reg 6=0xDEADBEEF afterwards; then sw $1,12($0) -> DMEM word 3=5.
REQ-034 beq $1,$1,+2 at PC 0 -> PC=12 next; beq $1,$2,+2 -> PC=4; j 0x10 -> PC=0x40.
REQ-035 addi $0,$0,9 -> reg 0 still reads 0; ori $7,$0,0xFFFF -> reg 7=0x0000FFFF; addi $8,$0,-1 -> reg 8=0xFFFFFFFF.
REQ-036 Drop rst_n mid-cycle while PC=0x20 -> PC=0 immediately with no clk edge; no writes occur while low.
